dct_da_coef: RTL

Parametrised, runtime-selectable 8-point DCT-II coefficient engine using bit-serial distributed arithmetic (DA). It computes any one coefficient X(k), k = 0..7, for one 8-sample block per transaction. Input and output use a valid/ready handshake, and the sample width is a parameter. It replaces the fixed per-coefficient DCT instances: one instance, or a bank of them, serves the front end of the compression pipeline ahead of RLE.

---
 rtl/dct_da_pkg.sv | 48 ++++
 rtl/dct_da_rom.sv | 29 ++
 rtl/dct_da_coef.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dct_da_pkg.sv
// dct_da_pkg: shared definitions for the distributed-arithmetic DCT engine.
//   - ROM_W / ROM_FRAC : width and fraction bits of the stored Q2.14 table
//   - frac_bits()      : fraction bits for a given coefficient word width
//   - state_e          : engine FSM states
//   - ROM_TABLE        : R[k][a] = round-half-away(2^14 * sum over set bits i
//                        of a of c(k)*cos((2i+1)k*pi/16)), k = 0..7, a = 0..15
//   - rom_coef()       : table lookup returning one Q2.14 word
package dct_da_pkg;

  localparam int unsigned ROM_W    = 16;
  localparam int unsigned ROM_FRAC = ROM_W - 2;

  function automatic int unsigned frac_bits(input int unsigned coef_w);
    return coef_w - 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Rows are k, columns are a with bit i of a selecting butterfly output u(i).
  localparam int ROM_TABLE [8][16] = '{
    '{0,  5793,  5793, 11585,  5793, 11585, 11585, 17378,
      5793, 11585, 11585, 17378, 11585, 17378, 17378, 23170},
    '{0,  8035,  6811, 14846,  4551, 12586, 11363, 19397,
      1598,  9633,  8410, 16444,  6149, 14184, 12961, 20995},
    '{0,  7568,  3135, 10703, -3135,  4433,     0,  7568,
     -7568,     0, -4433,  3135, -10703, -3135, -7568,   0},
    '{0,  6811, -1598,  5213, -8035, -1223, -9633, -2821,
     -4551,  2260, -6149,   662, -12586, -5774, -14184, -7373},
    '{0,  5793, -5793,     0, -5793,     0, -11585, -5793,
      5793, 11585,     0,  5793,     0,  5793, -5793,     0},
    '{0,  4551, -8035, -3483,  1598,  6149, -6436, -1885,
      6811, 11363, -1223,  3328,  8410, 12961,   375,  4926},
    '{0,  3135, -7568, -4433,  7568, 10703,     0,  3135,
     -3135,     0, -10703, -7568,  4433,  7568, -3135,    0},
    '{0,  1598, -4551, -2953,  6811,  8410,  2260,  3858,
     -8035, -6436, -12586, -10988, -1223,   375, -5774, -4176}
  };

  function automatic logic signed [ROM_W-1:0] rom_coef(input logic [2:0] k,
                                                       input logic [3:0] a);
    return ROM_W'(ROM_TABLE[k][a]);
  endfunction

endpackage

// File: rtl/dct_da_rom.sv
// dct_da_rom: combinational coefficient ROM for the DA engine.
//   k_i    [2:0]        coefficient index
//   a_i    [3:0]        DA address (bit i = current bit of u(i))
//   coef_o [COEF_W-1:0] signed Q2.(COEF_W-2) partial-sum coefficient
module dct_da_rom
  import dct_da_pkg::*;
#(
  parameter int unsigned COEF_W = 16
) (
  input  logic        [2:0]        k_i,
  input  logic        [3:0]        a_i,
  output logic signed [COEF_W-1:0] coef_o
);

  logic signed [ROM_W-1:0] base;

  assign base = rom_coef(k_i, a_i);

  // The table is stored at Q2.14; other word widths rescale it.
  if (COEF_W >= ROM_W) begin : g_wide
    assign coef_o = COEF_W'(base) <<< (COEF_W - ROM_W);
  end else begin : g_narrow
    localparam int unsigned SH = ROM_W - COEF_W;
    logic signed [ROM_W:0] rnd;
    assign rnd    = (ROM_W+1)'(base) + ((ROM_W+1)'(1) <<< (SH - 1));
    assign coef_o = COEF_W'(rnd >>> SH);
  end

endmodule

// File: rtl/dct_da_coef.sv
// dct_da_coef: runtime-selectable 8-point DCT-II coefficient engine using
// bit-serial distributed arithmetic. One coefficient X(k) per 8-sample block.
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    clock enable (all state holds when low)
//   in_valid / in_ready   input handshake; in_x0..in_x7 samples, in_k index
//   out_valid / out_ready output handshake
//   out_data [OUT_W-1:0]  X(k)*2^(COEF_W-2), full precision
//   out_k    [2:0]        index of the result
module dct_da_coef
  import dct_da_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = DATA_W + COEF_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x0,
  input  logic signed [DATA_W-1:0] in_x1,
  input  logic signed [DATA_W-1:0] in_x2,
  input  logic signed [DATA_W-1:0] in_x3,
  input  logic signed [DATA_W-1:0] in_x4,
  input  logic signed [DATA_W-1:0] in_x5,
  input  logic signed [DATA_W-1:0] in_x6,
  input  logic signed [DATA_W-1:0] in_x7,
  input  logic        [2:0]        in_k,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic        [2:0]        out_k
);

  localparam int unsigned U_W   = DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e                   state_q;
  logic signed [U_W-1:0]    u_q [4];
  logic        [2:0]        k_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic signed [OUT_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  acc_d;
  logic signed [OUT_W-1:0]  out_data_q;
  logic        [2:0]        out_k_q;
  logic                     out_valid_q;
  logic                     in_ready_q;

  logic signed [U_W-1:0]    x_ext [8];
  logic signed [U_W-1:0]    bfly  [4];
  logic        [3:0]        rom_a;
  logic signed [COEF_W-1:0] coef;
  logic signed [OUT_W-1:0]  coef_ext;
  logic                     accept;

  // Butterfly: even k uses symmetric sums, odd k antisymmetric differences.
  always_comb begin
    x_ext[0] = U_W'(in_x0);
    x_ext[1] = U_W'(in_x1);
    x_ext[2] = U_W'(in_x2);
    x_ext[3] = U_W'(in_x3);
    x_ext[4] = U_W'(in_x4);
    x_ext[5] = U_W'(in_x5);
    x_ext[6] = U_W'(in_x6);
    x_ext[7] = U_W'(in_x7);
    for (int unsigned i = 0; i < 4; i++) begin
      bfly[i] = in_k[0] ? (x_ext[i] - x_ext[7-i]) : (x_ext[i] + x_ext[7-i]);
    end
  end

  always_comb begin
    rom_a = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rom_a[i] = u_q[i][cnt_q];
    end
  end

  dct_da_rom #(
    .COEF_W(COEF_W)
  ) u_rom (
    .k_i   (k_q),
    .a_i   (rom_a),
    .coef_o(coef)
  );

  // The first (sign-bit) step subtracts: two's-complement MSB weight is negative.
  always_comb begin
    coef_ext = OUT_W'(coef);
    if (cnt_q == CNT_W'(DATA_W)) acc_d = (acc_q <<< 1) - coef_ext;
    else                         acc_d = (acc_q <<< 1) + coef_ext;
  end

  // In DONE the slot frees on the same edge the result retires.
  assign in_ready = in_ready_q | ((state_q == DONE) & out_ready);
  assign accept   = en & in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < 4; i++) u_q[i] <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (en) begin
      if (accept) begin
        for (int unsigned i = 0; i < 4; i++) u_q[i] <= bfly[i];
        k_q         <= in_k;
        cnt_q       <= CNT_W'(DATA_W);
        acc_q       <= '0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b0;
        state_q     <= CALC;
      end else begin
        unique case (state_q)
          IDLE: ;
          CALC: begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
              out_data_q  <= acc_d;
              out_k_q     <= k_q;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_k     = out_k_q;

endmodule
